naive_bus_rr_arbiter: RTL and testbench
=======================================

NAIVE_BUS_RR_ARBITER -- requirements
Module: naive_bus_rr_arbiter

Interface
REQ-001 SHALL have parameter N_MASTER, default 3, number of requesting bus masters (2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width; byte-enable width is DW/8.
REQ-004 SHALL run on one clock; reset is asynchronous and active-low: ports clk and rstn.
REQ-005 clk  input  1  system clock.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 m_rd_req  input  N_MASTER  per-master read request.
REQ-008 m_rd_addr  input  N_MASTER*AW  per-master read address, master i in slice i.
REQ-009 m_rd_gnt  output  N_MASTER  per-master read grant.
REQ-010 m_rd_data  output  N_MASTER*DW  per-master read data.
REQ-011 m_wr_req / m_wr_addr / m_wr_byte_en / m_wr_data  input  N_MASTER / N_MASTER*AW / N_MASTER*DW/8 / N_MASTER*DW  per-master write request fields.
REQ-012 m_wr_gnt  output  N_MASTER  per-master write grant.
REQ-013 s_rd_req, s_rd_addr  output  1, AW  shared slave read request.
REQ-014 s_rd_gnt, s_rd_data  input  1, DW  slave read grant; read data valid one cycle after the grant.
REQ-015 s_wr_req, s_wr_addr, s_wr_byte_en, s_wr_data  output  1, AW, DW/8, DW  shared slave write request.
REQ-016 s_wr_gnt  input  1  slave write grant.

Function
REQ-017 Master i SHALL be "requesting" when m_rd_req[i] | m_wr_req[i].
REQ-018 Winner SHALL be the first requesting index found scanning upward from pointer ptr, wrapping from N_MASTER-1 to 0.
REQ-019 Winner's request SHALL be forwarded combinationally to the slave port (zero added request latency); non-winners see gnt 0.
REQ-020 When the winner asserts both rd_req and wr_req, only the read SHALL be forwarded; the write is forwarded in a later cycle.
REQ-021 m_rd_gnt[winner] = s_rd_gnt and m_wr_gnt[winner] = s_wr_gnt, gated by the forwarded operation; all other grant bits SHALL be 0.
REQ-022 ptr SHALL update to (winner+1) mod N_MASTER only on a cycle with a slave grant; it holds otherwise.
REQ-023 On a slave stall (req without gnt), the winner SHALL remain the winner while it keeps requesting; if it drops its request, arbitration reruns that cycle.
REQ-024 No requesters -> s_rd_req = s_wr_req = 0; address, data and byte-enable outputs = 0; ptr holds.
REQ-025 On a read grant, rd_owner_vld SHALL be set to 1 and rd_owner to the winner index, both registered; otherwise rd_owner_vld SHALL be set to 0.
REQ-026 In the cycle after a read grant, s_rd_data SHALL be routed to m_rd_data[rd_owner]; every other m_rd_data slice, and all slices when rd_owner_vld = 0, SHALL be 0.
REQ-027 Back-to-back read grants to different masters SHALL deliver each datum to its own owner, one cycle after the respective grant.
REQ-028 Fairness: a continuously requesting master SHALL be granted within N_MASTER consecutive slave grants.
REQ-029 ptr arithmetic SHALL be $clog2(N_MASTER) bits wide (minimum 1) with explicit wrap; it must not index beyond N_MASTER-1.

Reset
REQ-030 While rstn = 0: ptr = 0, rd_owner_vld = 0, rd_owner = 0; all grant and m_rd_data outputs = 0.
REQ-031 Reset asserted mid-read (after grant, before data) SHALL discard the pending datum; no m_rd_data is delivered after rstn rises.
REQ-032 First arbitration after reset release SHALL start its scan at master 0.

Structure
REQ-033 The combinational round-robin priority picker SHALL be the sub-module rr_pick (inputs: request vector, ptr; outputs: one-hot winner, winner index).
REQ-034 No new package content is needed; N_MASTER stays a module parameter set by the instantiating top.

Verification
REQ-035 Reset, then master 1 reads 0x0001_0004 with slave data 0xDEAD_BEEF -> m_rd_gnt = 3'b010 in the same cycle; m_rd_data[1] = 0xDEAD_BEEF the next cycle; other slices 0.
REQ-036 Masters 0, 1 and 2 request reads continuously, slave always grants -> grant order 0,1,2,0,1,2.
REQ-037 Master 2 writes 0x0002_0010, data 0x1234_5678, byte_en 4'b0011, with s_wr_gnt held low 3 cycles -> s_wr_* stable for 4 cycles; m_wr_gnt[2] pulses once; ptr moves to 0.
REQ-038 Master 0 asserts rd and wr simultaneously -> read granted first; write granted on a later cycle; ptr advances after each.
REQ-039 Read grant to master 1, then rstn pulsed low before the next edge -> after release, no m_rd_data nonzero; ptr = 0.
REQ-040 Master 0 reads A, then master 2 reads B on consecutive granted cycles -> m_rd_data[0] = A at t+1; m_rd_data[2] = B at t+2.

Source files
------------

// File: rtl/naive_bus_rr_arbiter_pkg.sv
// Shared helpers for the naive bus round-robin arbiter slice.
package naive_bus_rr_arbiter_pkg;

  // Pointer/index width for n masters, never narrower than one bit.
  function automatic int unsigned ptrWidth(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/naive_bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping.
module rr_pick
  import naive_bus_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTER = 3,
  parameter int unsigned PW       = ptrWidth(N_MASTER)
) (
  input  logic [N_MASTER-1:0] req_i,
  input  logic [PW-1:0]       ptr_i,
  output logic [N_MASTER-1:0] winOh_o,
  output logic [PW-1:0]       winIdx_o
);

  always_comb begin
    logic        found;
    logic [PW:0] pos;
    found    = 1'b0;
    pos      = '0;
    winOh_o  = '0;
    winIdx_o = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      // Extra bit keeps ptr+k from overflowing before the explicit wrap.
      pos = {1'b0, ptr_i} + (PW+1)'(k);
      if (pos >= (PW+1)'(N_MASTER)) begin
        pos = pos - (PW+1)'(N_MASTER);
      end
      if (!found && req_i[pos[PW-1:0]]) begin
        found                  = 1'b1;
        winOh_o[pos[PW-1:0]]   = 1'b1;
        winIdx_o               = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/naive_bus_rr_arbiter.sv
// Round-robin arbiter funnelling N_MASTER read/write masters onto one slave port.
module naive_bus_rr_arbiter
  import naive_bus_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTER = 3,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_MASTER-1:0]        m_rd_req,
  input  logic [N_MASTER*AW-1:0]     m_rd_addr,
  output logic [N_MASTER-1:0]        m_rd_gnt,
  output logic [N_MASTER*DW-1:0]     m_rd_data,
  input  logic [N_MASTER-1:0]        m_wr_req,
  input  logic [N_MASTER*AW-1:0]     m_wr_addr,
  input  logic [N_MASTER*DW/8-1:0]   m_wr_byte_en,
  input  logic [N_MASTER*DW-1:0]     m_wr_data,
  output logic [N_MASTER-1:0]        m_wr_gnt,
  output logic                       s_rd_req,
  output logic [AW-1:0]              s_rd_addr,
  input  logic                       s_rd_gnt,
  input  logic [DW-1:0]              s_rd_data,
  output logic                       s_wr_req,
  output logic [AW-1:0]              s_wr_addr,
  output logic [DW/8-1:0]            s_wr_byte_en,
  output logic [DW-1:0]              s_wr_data,
  input  logic                       s_wr_gnt
);

  localparam int unsigned PW = ptrWidth(N_MASTER);
  localparam int unsigned BW = DW / 8;

  logic [N_MASTER-1:0] reqVec;
  logic [N_MASTER-1:0] winOh;
  logic [PW-1:0]       winIdx;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       rdOwner_q, rdOwner_d;
  logic                rdOwnerVld_q, rdOwnerVld_d;
  logic                rdFire, wrFire;

  assign reqVec = m_rd_req | m_wr_req;

  rr_pick #(
    .N_MASTER (N_MASTER),
    .PW       (PW)
  ) u_pick (
    .req_i    (reqVec),
    .ptr_i    (ptr_q),
    .winOh_o  (winOh),
    .winIdx_o (winIdx)
  );

  // A winner with both requests pending sends its read first; its write wins a later cycle.
  always_comb begin
    s_rd_req     = 1'b0;
    s_rd_addr    = '0;
    s_wr_req     = 1'b0;
    s_wr_addr    = '0;
    s_wr_byte_en = '0;
    s_wr_data    = '0;
    m_rd_gnt     = '0;
    m_wr_gnt     = '0;
    if (rstn) begin
      for (int i = 0; i < N_MASTER; i++) begin
        if (winOh[i]) begin
          if (m_rd_req[i]) begin
            s_rd_req    = 1'b1;
            s_rd_addr   = m_rd_addr[i*AW +: AW];
            m_rd_gnt[i] = s_rd_gnt;
          end else begin
            s_wr_req     = 1'b1;
            s_wr_addr    = m_wr_addr[i*AW +: AW];
            s_wr_byte_en = m_wr_byte_en[i*BW +: BW];
            s_wr_data    = m_wr_data[i*DW +: DW];
            m_wr_gnt[i]  = s_wr_gnt;
          end
        end
      end
    end
  end

  assign rdFire = s_rd_req & s_rd_gnt;
  assign wrFire = s_wr_req & s_wr_gnt;

  always_comb begin
    ptr_d        = ptr_q;
    rdOwnerVld_d = rdFire;
    rdOwner_d    = rdFire ? winIdx : rdOwner_q;
    if (rdFire || wrFire) begin
      ptr_d = (winIdx == PW'(N_MASTER - 1)) ? '0 : winIdx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q        <= '0;
      rdOwner_q    <= '0;
      rdOwnerVld_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      rdOwner_q    <= rdOwner_d;
      rdOwnerVld_q <= rdOwnerVld_d;
    end
  end

  // Slave read data lands one cycle after its grant, steered to whoever held that grant.
  always_comb begin
    m_rd_data = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (rdOwnerVld_q && (rdOwner_q == PW'(i))) begin
        m_rd_data[i*DW +: DW] = s_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_naive_bus_rr_arbiter.sv
// Bench for naive_bus_rr_arbiter: directed scenarios plus random traffic against a reference model.
module tb_naive_bus_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    m_rd_req = '0;
  logic [N*AW-1:0] m_rd_addr = '0;
  logic [N-1:0]    m_rd_gnt;
  logic [N*DW-1:0] m_rd_data;
  logic [N-1:0]    m_wr_req = '0;
  logic [N*AW-1:0] m_wr_addr = '0;
  logic [N*BW-1:0] m_wr_byte_en = '0;
  logic [N*DW-1:0] m_wr_data = '0;
  logic [N-1:0]    m_wr_gnt;
  logic            s_rd_req;
  logic [AW-1:0]   s_rd_addr;
  logic            s_rd_gnt = 1'b0;
  logic [DW-1:0]   s_rd_data = '0;
  logic            s_wr_req;
  logic [AW-1:0]   s_wr_addr;
  logic [BW-1:0]   s_wr_byte_en;
  logic [DW-1:0]   s_wr_data;
  logic            s_wr_gnt = 1'b0;

  always #5 clk = ~clk;

  naive_bus_rr_arbiter #(
    .N_MASTER (N),
    .AW       (AW),
    .DW       (DW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m_rd_req     (m_rd_req),
    .m_rd_addr    (m_rd_addr),
    .m_rd_gnt     (m_rd_gnt),
    .m_rd_data    (m_rd_data),
    .m_wr_req     (m_wr_req),
    .m_wr_addr    (m_wr_addr),
    .m_wr_byte_en (m_wr_byte_en),
    .m_wr_data    (m_wr_data),
    .m_wr_gnt     (m_wr_gnt),
    .s_rd_req     (s_rd_req),
    .s_rd_addr    (s_rd_addr),
    .s_rd_gnt     (s_rd_gnt),
    .s_rd_data    (s_rd_data),
    .s_wr_req     (s_wr_req),
    .s_wr_addr    (s_wr_addr),
    .s_wr_byte_en (s_wr_byte_en),
    .s_wr_data    (s_wr_data),
    .s_wr_gnt     (s_wr_gnt)
  );

  int assertCount = 0;
  int failCount   = 0;
  int mPtr   = 0;
  int mOwner = -1;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] rdReq, input logic [N-1:0] wrReq,
                               input logic rdGnt, input logic wrGnt, input logic [DW-1:0] rdData);
    m_rd_req  = rdReq;
    m_wr_req  = wrReq;
    s_rd_gnt  = rdGnt;
    s_wr_gnt  = wrGnt;
    s_rd_data = rdData;
  endtask

  // Reference arbitration: scan upward from the pointer, modulo N.
  function automatic int modelWinner();
    if (!rstn) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mPtr + k) % N;
      if (m_rd_req[j] || m_wr_req[j]) return j;
    end
    return -1;
  endfunction

  task automatic cycleCheck(input string tag);
    int w;
    bit rdFire, wrFire;
    logic [N-1:0]    eRdGnt, eWrGnt;
    logic            eSRdReq, eSWrReq;
    logic [AW-1:0]   eRdAddr, eWrAddr;
    logic [BW-1:0]   eBe;
    logic [DW-1:0]   eWrData;
    logic [N*DW-1:0] eRdData;
    #1;
    rdFire = 0; wrFire = 0;
    eRdGnt = '0; eWrGnt = '0; eSRdReq = 0; eSWrReq = 0;
    eRdAddr = '0; eWrAddr = '0; eBe = '0; eWrData = '0; eRdData = '0;
    w = modelWinner();
    for (int i = 0; i < N; i++) begin
      if (i == w) begin
        if (m_rd_req[i]) begin
          eSRdReq   = 1'b1;
          eRdAddr   = m_rd_addr[i*AW +: AW];
          eRdGnt[i] = s_rd_gnt;
          rdFire    = s_rd_gnt;
        end else begin
          eSWrReq   = 1'b1;
          eWrAddr   = m_wr_addr[i*AW +: AW];
          eBe       = m_wr_byte_en[i*BW +: BW];
          eWrData   = m_wr_data[i*DW +: DW];
          eWrGnt[i] = s_wr_gnt;
          wrFire    = s_wr_gnt;
        end
      end
      if (i == mOwner) eRdData[i*DW +: DW] = s_rd_data;
    end
    checkOutput($sformatf("%s.rdGnt", tag), m_rd_gnt, eRdGnt);
    checkOutput($sformatf("%s.wrGnt", tag), m_wr_gnt, eWrGnt);
    checkOutput($sformatf("%s.sRdReq", tag), s_rd_req, eSRdReq);
    checkOutput($sformatf("%s.sRdAddr", tag), s_rd_addr, eRdAddr);
    checkOutput($sformatf("%s.sWrReq", tag), s_wr_req, eSWrReq);
    checkOutput($sformatf("%s.sWrAddr", tag), s_wr_addr, eWrAddr);
    checkOutput($sformatf("%s.sWrBe", tag), s_wr_byte_en, eBe);
    checkOutput($sformatf("%s.sWrData", tag), s_wr_data, eWrData);
    checkOutput($sformatf("%s.rdData", tag), m_rd_data, eRdData);
    @(posedge clk);
    if (!rstn) begin
      mPtr = 0;
      mOwner = -1;
    end else begin
      if (rdFire || wrFire) mPtr = (w + 1) % N;
      mOwner = rdFire ? w : -1;
    end
    #1;
  endtask

  task automatic expectGnt(input string tag, input logic [N-1:0] rdGnt, input logic [N-1:0] wrGnt);
    #1;
    checkOutput($sformatf("%s.gntRd", tag), m_rd_gnt, rdGnt);
    checkOutput($sformatf("%s.gntWr", tag), m_wr_gnt, wrGnt);
  endtask

  task automatic resetDut();
    rstn   = 1'b0;
    mPtr   = 0;
    mOwner = -1;
    applyStimulus('1, '1, 1'b1, 1'b1, $urandom);
    cycleCheck("reset");
    rstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_rd_addr[i*AW +: AW] = 32'h1000_0000 + 32'(i * 16);
      m_wr_addr[i*AW +: AW] = 32'h2000_0000 + 32'(i * 16);
      m_wr_data[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
      m_wr_byte_en[i*BW +: BW] = 4'hF;
    end

    // Single read by master 1, datum one cycle later
    resetDut();
    m_rd_addr[1*AW +: AW] = 32'h0001_0004;
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt("rd1", 3'b010, 3'b000);
    cycleCheck("rd1");
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'hDEAD_BEEF);
    #1;
    checkOutput("rd1.data", m_rd_data, {32'h0, 32'hDEAD_BEEF, 32'h0});
    cycleCheck("rd1.after");

    // Three continuous readers, slave always grants
    resetDut();
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      expectGnt($sformatf("rr%0d", k), 3'(1 << (k % 3)), 3'b000);
      cycleCheck($sformatf("rr%0d", k));
    end

    // Stalled write from master 2
    resetDut();
    m_wr_addr[2*AW +: AW]    = 32'h0002_0010;
    m_wr_data[2*DW +: DW]    = 32'h1234_5678;
    m_wr_byte_en[2*BW +: BW] = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b000, 3'b100, 1'b0, (k == 3), 32'h0);
      #1;
      checkOutput($sformatf("wr2.%0d.addr", k), s_wr_addr, 32'h0002_0010);
      expectGnt($sformatf("wr2.%0d", k), 3'b000, (k == 3) ? 3'b100 : 3'b000);
      cycleCheck($sformatf("wr2.%0d", k));
    end
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt("wr2.wrap", 3'b001, 3'b000);
    cycleCheck("wr2.wrap");

    // Master 0 with read and write together
    resetDut();
    applyStimulus(3'b001, 3'b001, 1'b1, 1'b1, 32'h0);
    expectGnt("rw0.a", 3'b001, 3'b000);
    cycleCheck("rw0.a");
    applyStimulus(3'b000, 3'b001, 1'b1, 1'b1, 32'h0);
    expectGnt("rw0.b", 3'b000, 3'b001);
    cycleCheck("rw0.b");
    applyStimulus(3'b011, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt("rw0.c", 3'b010, 3'b000);
    cycleCheck("rw0.c");

    // Reset pulse between a read grant and its datum
    resetDut();
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt("rst", 3'b010, 3'b000);
    cycleCheck("rst");
    rstn = 1'b0;
    mPtr = 0;
    mOwner = -1;
    #2;
    rstn = 1'b1;
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'hCAFE_F00D);
    #1;
    checkOutput("rst.data", m_rd_data, '0);
    cycleCheck("rst.data");
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 32'hCAFE_F00D);
    expectGnt("rst.ptr", 3'b001, 3'b000);
    cycleCheck("rst.ptr");

    // Back-to-back reads to masters 0 and 2
    resetDut();
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 32'h0);
    cycleCheck("b2b.0");
    applyStimulus(3'b100, 3'b000, 1'b1, 1'b0, 32'hAAAA_0001);
    #1;
    checkOutput("b2b.dataA", m_rd_data, {32'h0, 32'h0, 32'hAAAA_0001});
    cycleCheck("b2b.1");
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'hBBBB_0002);
    #1;
    checkOutput("b2b.dataB", m_rd_data, {32'hBBBB_0002, 32'h0, 32'h0});
    cycleCheck("b2b.2");

    // Random traffic with stalls and occasional resets
    resetDut();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) resetDut();
      m_rd_addr    = {$urandom, $urandom, $urandom};
      m_wr_addr    = {$urandom, $urandom, $urandom};
      m_wr_data    = {$urandom, $urandom, $urandom};
      m_wr_byte_en = 12'($urandom);
      applyStimulus(3'($urandom) & 3'($urandom), 3'($urandom) & 3'($urandom),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), $urandom);
      cycleCheck($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
